// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - write-request and register-bank signal bundle for reg_write_arbiter
interface reg_write_arbiter_if;
  // Source A (ALU writeback) request
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  // Source B (load writeback) request
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  // Register-bank side
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        regwrite;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        stall;
  logic        idle;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, ra1, ra2,
    input  a_ready, b_ready, regwrite, wa, wd, stall, idle
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, ra1, ra2,
    output a_ready, b_ready, regwrite, wa, wd, stall, idle
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-source round-robin register-file write arbiter with RAW hazard flag
// Optional feature macro: RB_ZERO_GUARD_EN (entries for address 0 are consumed without writing,
// and address 0 never raises stall).
module reg_write_arbiter #(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  reg_write_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 3;

`ifdef RB_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  // Index 0 is source A, index 1 is source B throughout.
  logic [4:0]    addr_mem_q [2][DEPTH];
  logic [31:0]   data_mem_q [2][DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  // last_b_q = 1 means source B received the most recent grant.
  logic          last_b_q, last_b_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;

  logic [1:0]    in_valid;
  logic [4:0]    in_addr [2];
  logic [31:0]   in_data [2];
  logic [1:0]    ready;
  logic [1:0]    push;
  logic [1:0]    not_empty;
  logic [1:0]    grant;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic          stall;
  logic [PW:0]   slot;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A read address collides with a pending write address; address 0 is exempt under the guard.
  function automatic logic addr_hit(input logic [4:0] a, input logic [4:0] r1, input logic [4:0] r2);
    return ((a == r1) || (a == r2)) && !(ZERO_GUARD && (a == 5'd0));
  endfunction

  assign in_valid   = {bus.b_valid, bus.a_valid};
  assign in_addr[0] = bus.a_addr;
  assign in_addr[1] = bus.b_addr;
  assign in_data[0] = bus.a_data;
  assign in_data[1] = bus.b_data;

  // Per-source acceptance and occupancy; ready depends only on the current count.
  always_comb begin
    ready     = '0;
    push      = '0;
    not_empty = '0;
    for (int s = 0; s < 2; s++) begin
      ready[s]     = (cnt_q[s] < CW'(DEPTH));
      push[s]      = in_valid[s] & ready[s];
      not_empty[s] = (cnt_q[s] != '0);
    end
  end

  // Round-robin grant: A wins contention only if B was granted last.
  always_comb begin
    grant     = '0;
    grant[0]  = not_empty[0] & (~not_empty[1] | last_b_q);
    grant[1]  = not_empty[1] & ~grant[0];
    head_addr = grant[1] ? addr_mem_q[1][rd_ptr_q[1]] : addr_mem_q[0][rd_ptr_q[0]];
    head_data = grant[1] ? data_mem_q[1][rd_ptr_q[1]] : data_mem_q[0][rd_ptr_q[0]];
  end

  // Next-state for queue pointers/counts and the registered bank-write outputs.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wr_ptr_d[s] = push[s]  ? next_ptr(wr_ptr_q[s]) : wr_ptr_q[s];
      rd_ptr_d[s] = grant[s] ? next_ptr(rd_ptr_q[s]) : rd_ptr_q[s];
      case ({push[s], grant[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + CW'(1);
        2'b01:   cnt_d[s] = cnt_q[s] - CW'(1);
        default: cnt_d[s] = cnt_q[s];
      endcase
    end
    last_b_d   = last_b_q;
    regwrite_d = 1'b1;
    wa_d       = wa_q;
    wd_d       = wd_q;
    if (|grant) begin
      last_b_d = grant[1];
      if (!(ZERO_GUARD && (head_addr == 5'd0))) begin
        regwrite_d = 1'b0;
        wa_d       = head_addr;
        wd_d       = head_data;
      end
    end
  end

  // Control state; reset drops every pending entry and parks the pointer on B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      last_b_q   <= 1'b1;
      regwrite_q <= 1'b1;
      wa_q       <= '0;
      wd_q       <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      last_b_q   <= last_b_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
    end
  end

  // Queue storage; contents are only meaningful where the count says so, so no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s] && rst_n) begin
        addr_mem_q[s][wr_ptr_q[s]] <= in_addr[s];
        data_mem_q[s][wr_ptr_q[s]] <= in_data[s];
      end
    end
  end

  // Hazard: any occupied slot of either queue, or the write currently on the bank port.
  always_comb begin
    stall = 1'b0;
    slot  = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot = {1'b0, rd_ptr_q[s]} + (PW + 1)'(k);
        if (slot >= (PW + 1)'(DEPTH)) begin
          slot = slot - (PW + 1)'(DEPTH);
        end
        if ((CW'(k) < cnt_q[s]) && addr_hit(addr_mem_q[s][slot[PW-1:0]], bus.ra1, bus.ra2)) begin
          stall = 1'b1;
        end
      end
    end
    if (!regwrite_q && addr_hit(wa_q, bus.ra1, bus.ra2)) begin
      stall = 1'b1;
    end
  end

  assign bus.a_ready  = ready[0];
  assign bus.b_ready  = ready[1];
  assign bus.regwrite = regwrite_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.stall    = stall;
  assign bus.idle     = ~not_empty[0] & ~not_empty[1] & regwrite_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter against a queue-based model
module tb_reg_write_arbiter;

  localparam int DEPTH = 2;

`ifdef RB_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  reg_write_arbiter_if bus();

  reg_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  // Reference model: one queue per source plus the bank-port view.
  wr_t         qa[$];
  wr_t         qb[$];
  logic        m_last_b = 1'b1;
  logic        m_rw     = 1'b1;
  logic [4:0]  m_wa     = '0;
  logic [31:0] m_wd     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [4:0] a, input logic [4:0] r1, input logic [4:0] r2);
    if (ZG && a == 5'd0) return 1'b0;
    return (a == r1) || (a == r2);
  endfunction

  function automatic logic m_stall(input logic [4:0] r1, input logic [4:0] r2);
    logic s;
    s = 1'b0;
    foreach (qa[i]) if (m_hit(qa[i].addr, r1, r2)) s = 1'b1;
    foreach (qb[i]) if (m_hit(qb[i].addr, r1, r2)) s = 1'b1;
    if (!m_rw && m_hit(m_wa, r1, r2)) s = 1'b1;
    return s;
  endfunction

  function automatic void m_take(input wr_t e);
    if (ZG && e.addr == 5'd0) begin
      m_rw = 1'b1;
    end else begin
      m_rw = 1'b0;
      m_wa = e.addr;
      m_wd = e.data;
    end
  endfunction

  // One clock cycle: drive, check combinational outputs, advance the model, check the bank port.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic acc_a, acc_b, ga, gb;
    wr_t  e;
    @(negedge clk);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    bus.ra1 = r1;     bus.ra2 = r2;
    #1;
    check("a_ready", bus.a_ready, (qa.size() < DEPTH));
    check("b_ready", bus.b_ready, (qb.size() < DEPTH));
    check("stall",   bus.stall,   m_stall(r1, r2));
    check("idle",    bus.idle,    (qa.size() == 0 && qb.size() == 0 && m_rw));
    @(posedge clk);
    acc_a = av && (qa.size() < DEPTH);
    acc_b = bv && (qb.size() < DEPTH);
    ga = (qa.size() > 0) && ((qb.size() == 0) || m_last_b);
    gb = (qb.size() > 0) && !ga;
    if (ga) begin
      e = qa.pop_front(); m_last_b = 1'b0; m_take(e);
    end else if (gb) begin
      e = qb.pop_front(); m_last_b = 1'b1; m_take(e);
    end else begin
      m_rw = 1'b1;
    end
    if (acc_a) qa.push_back('{addr: aa, data: ad});
    if (acc_b) qb.push_back('{addr: ba, data: bd});
    #1;
    check("regwrite", bus.regwrite, m_rw);
    check("wa",       bus.wa,       m_wa);
    check("wd",       bus.wd,       m_wd);
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    m_last_b = 1'b1; m_rw = 1'b1; m_wa = '0; m_wd = '0;
    #1;
    check("rst_regwrite", bus.regwrite, 1'b1);
    check("rst_wa",       bus.wa,       5'd0);
    check("rst_wd",       bus.wd,       32'd0);
    check("rst_a_ready",  bus.a_ready,  1'b1);
    check("rst_b_ready",  bus.b_ready,  1'b1);
    check("rst_stall",    bus.stall,    1'b0);
    check("rst_idle",     bus.idle,     1'b1);
    @(posedge clk);
    #1;
    check("rst_no_write", bus.regwrite, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        av, bv;
    logic [4:0]  aa, ba, r1, r2;
    logic [31:0] ad, bd;

    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.ra1 = 5'd31;    bus.ra2 = 5'd31;

    do_reset();

    // Single write with latency and return to idle
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
    idle_step();
    check("single_wa", bus.wa, 5'd5);
    check("single_wd", bus.wd, 32'hDEADBEEF);
    idle_step();
    idle_step();

    // Contention right after reset: A first, then B
    do_reset();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd31, 5'd31);
    idle_step();
    check("cont_first_wa", bus.wa, 5'd3);
    idle_step();
    check("cont_second_wa", bus.wa, 5'd4);
    idle_step();

    // Both sources flood; B queue fills and extra B requests are dropped
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5'(8 + i), 32'hA000 + i, 1'b1, 5'(16 + i), 32'hB000 + i, 5'd31, 5'd31);
    end
    for (int i = 0; i < 6; i++) idle_step();

    // Hazard on a pending then in-flight write
    step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd7, 5'd31);
    step(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd7, 5'd31);
    step(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd7, 5'd31);
    step(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd7, 5'd31);

    // Address 0 handling (written normally unless the guard is built in)
    step(1'b1, 5'd0, 32'h5A5A, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle_step();
    idle_step();

    // Reset with entries pending: nothing may be written afterwards
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd31, 5'd31);
    step(1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC, 5'd31, 5'd31);
    do_reset();
    idle_step();
    idle_step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        av = ($urandom_range(0, 9) < 6);
        bv = ($urandom_range(0, 9) < 6);
        aa = 5'($urandom_range(0, 7));
        ba = 5'($urandom_range(0, 7));
        ad = $urandom;
        bd = $urandom;
        r1 = 5'($urandom_range(0, 9));
        r2 = 5'($urandom_range(0, 9));
        step(av, aa, ad, bv, ba, bd, r1, r2);
      end
    end
    for (int i = 0; i < 6; i++) idle_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
